// File: rtl/ex.sv
// rtl/ex.sv - MIPS execute stage: ALU, HI/LO file, single-cycle multiply and restoring divider
// Latches the ID bundle under stall control and issues the data-SRAM request from the EX register.
module ex (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic         stallreq_for_ex,
    output logic [75:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_rf_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    logic [158:0] id_bus_q;

    logic [31:0]  pc;
    logic [31:0]  inst;
    logic [11:0]  alu_op;
    logic [2:0]   sel_alu_src1;
    logic [3:0]   sel_alu_src2;
    logic         data_ram_en;
    logic [3:0]   data_ram_wen;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic         sel_rf_res;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;

    // A downstream-free bubble replaces the held instruction so it is not issued twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_bus_q <= '0;
        end else if (stall[2] == STOP && stall[3] != STOP) begin
            id_bus_q <= '0;
        end else if (stall[2] != STOP) begin
            id_bus_q <= id_to_ex_bus;
        end
    end

    assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_bus_q;

    logic [31:0] imm_zext;
    logic [31:0] imm_sext;
    logic [31:0] sa_zext;
    logic [31:0] src1;
    logic [31:0] src2;

    assign imm_zext = {16'h0000, inst[15:0]};
    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign sa_zext  = {27'd0, inst[10:6]};

    assign src1 = ({32{sel_alu_src1[0]}} & rdata1)
                | ({32{sel_alu_src1[1]}} & pc)
                | ({32{sel_alu_src1[2]}} & sa_zext);

    assign src2 = ({32{sel_alu_src2[0]}} & rdata2)
                | ({32{sel_alu_src2[1]}} & imm_sext)
                | ({32{sel_alu_src2[2]}} & 32'd8)
                | ({32{sel_alu_src2[3]}} & imm_zext);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;
    logic [31:0] alu_result;
    logic [4:0]  shamt;

    assign shamt    = src1[4:0];
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'd0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'd0, src1 < src2};
    assign sll_res  = src2 << shamt;
    assign srl_res  = src2 >> shamt;
    assign sra_res  = $signed(src2) >>> shamt;
    assign lui_res  = {src2[15:0], 16'h0000};

    assign alu_result = ({32{alu_op[11]}} & add_res)
                      | ({32{alu_op[10]}} & sub_res)
                      | ({32{alu_op[9]}}  & slt_res)
                      | ({32{alu_op[8]}}  & sltu_res)
                      | ({32{alu_op[7]}}  & (src1 & src2))
                      | ({32{alu_op[6]}}  & ~(src1 | src2))
                      | ({32{alu_op[5]}}  & (src1 | src2))
                      | ({32{alu_op[4]}}  & (src1 ^ src2))
                      | ({32{alu_op[3]}}  & sll_res)
                      | ({32{alu_op[2]}}  & srl_res)
                      | ({32{alu_op[1]}}  & sra_res)
                      | ({32{alu_op[0]}}  & lui_res);

    logic is_special;
    logic inst_mfhi;
    logic inst_mflo;
    logic inst_mthi;
    logic inst_mtlo;
    logic inst_mult;
    logic inst_multu;
    logic inst_div;
    logic inst_divu;
    logic inst_div_any;

    assign is_special   = (inst[31:26] == 6'h00);
    assign inst_mfhi    = is_special && (inst[5:0] == 6'h10);
    assign inst_mthi    = is_special && (inst[5:0] == 6'h11);
    assign inst_mflo    = is_special && (inst[5:0] == 6'h12);
    assign inst_mtlo    = is_special && (inst[5:0] == 6'h13);
    assign inst_mult    = is_special && (inst[5:0] == 6'h18);
    assign inst_multu   = is_special && (inst[5:0] == 6'h19);
    assign inst_div     = is_special && (inst[5:0] == 6'h1A);
    assign inst_divu    = is_special && (inst[5:0] == 6'h1B);
    assign inst_div_any = inst_div || inst_divu;

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
    assign prod_u = {32'd0, rdata1} * {32'd0, rdata2};

    div_state_e  div_state_q;
    div_state_e  div_state_d;
    logic [31:0] div_rem_q;
    logic [31:0] div_quo_q;
    logic [31:0] div_den_q;
    logic [31:0] div_num_raw_q;
    logic        div_neg_quo_q;
    logic        div_neg_rem_q;
    logic        div_by_zero_q;
    logic [5:0]  div_cnt_q;

    logic [31:0] num_abs;
    logic [31:0] den_abs;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_fits;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    assign num_abs = (inst_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
    assign den_abs = (inst_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;

    // Quotient bits enter at the bottom of div_quo_q as dividend bits leave the top.
    assign div_shift = {div_rem_q, div_quo_q[31]};
    assign div_trial = div_shift - {1'b0, div_den_q};
    assign div_fits  = (div_shift >= {1'b0, div_den_q});

    assign div_quotient  = div_by_zero_q ? 32'hFFFF_FFFF :
                           div_neg_quo_q ? (32'd0 - div_quo_q) : div_quo_q;
    assign div_remainder = div_by_zero_q ? div_num_raw_q :
                           div_neg_rem_q ? (32'd0 - div_rem_q) : div_rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            DIV_IDLE: if (inst_div_any) div_state_d = DIV_BUSY;
            DIV_BUSY: if (div_cnt_q == 6'd31) div_state_d = DIV_DONE;
            DIV_DONE: if (stall[2] != STOP) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        stallreq_for_ex = 1'b0;
        case (div_state_q)
            DIV_IDLE: stallreq_for_ex = inst_div_any;
            DIV_BUSY: stallreq_for_ex = 1'b1;
            default:  stallreq_for_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_rem_q     <= '0;
            div_quo_q     <= '0;
            div_den_q     <= '0;
            div_num_raw_q <= '0;
            div_neg_quo_q <= 1'b0;
            div_neg_rem_q <= 1'b0;
            div_by_zero_q <= 1'b0;
            div_cnt_q     <= '0;
        end else if (div_state_q == DIV_IDLE && inst_div_any) begin
            div_rem_q     <= '0;
            div_quo_q     <= num_abs;
            div_den_q     <= den_abs;
            div_num_raw_q <= rdata1;
            div_neg_quo_q <= inst_div && (rdata1[31] ^ rdata2[31]);
            div_neg_rem_q <= inst_div && rdata1[31];
            div_by_zero_q <= (rdata2 == 32'd0);
            div_cnt_q     <= '0;
        end else if (div_state_q == DIV_BUSY) begin
            div_rem_q <= div_fits ? div_trial[31:0] : div_shift[31:0];
            div_quo_q <= {div_quo_q[30:0], div_fits};
            div_cnt_q <= div_cnt_q + 6'd1;
        end
    end

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // HI/LO change only on the edge the owning instruction leaves EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (stall[2] != STOP) begin
            if (inst_mthi) begin
                hi_q <= rdata1;
            end else if (inst_mtlo) begin
                lo_q <= rdata1;
            end else if (inst_mult) begin
                {hi_q, lo_q} <= prod_s;
            end else if (inst_multu) begin
                {hi_q, lo_q} <= prod_u;
            end else if (inst_div_any && div_state_q == DIV_DONE) begin
                hi_q <= div_remainder;
                lo_q <= div_quotient;
            end
        end
    end

    logic [31:0] ex_result;

    assign ex_result = inst_mfhi ? hi_q :
                       inst_mflo ? lo_q : alu_result;

    assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
    assign data_sram_en    = data_ram_en;
    assign data_sram_wen   = data_ram_wen;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rdata2;

    logic unused_bits;
    assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - scoreboard bench for ex: directed test-plan cases plus randomized instruction stream
module tb_ex;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [5:0]   force_stall;
    logic [158:0] id_to_ex_bus;
    logic         stallreq_for_ex;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    ex dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .stallreq_for_ex (stallreq_for_ex),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline controller: the divider request freezes fetch, decode, EX and the MEM input.
    assign stall = force_stall | ({6{stallreq_for_ex}} & 6'b001111);

    typedef struct {
        logic [75:0] mem;
        logic [37:0] rf;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        zero_e;
    int          vectors;
    int          miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        loaded;
    logic        rand_stall;

    task automatic chk(input string name, input logic [75:0] got, input logic [75:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sel,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, sel, r1, r2};
    endfunction

    // Reference model: architectural effect of one instruction, applied in program order.
    task automatic model_exec(input logic [158:0] b, output exp_t e);
        logic [31:0] pc, inst, r1, r2, a, bb, alu, res;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic        en, we, sel;
        logic [3:0]  wen;
        logic [4:0]  wa;
        longint      sn, sd, sp;
        longint unsigned un, ud, up;
        {pc, inst, op, s1, s2, en, wen, we, wa, sel, r1, r2} = b;
        a  = s1[0] ? r1 : s1[1] ? pc : s1[2] ? {27'd0, inst[10:6]} : 32'd0;
        bb = s2[0] ? r2 : s2[1] ? {{16{inst[15]}}, inst[15:0]} :
             s2[2] ? 32'd8 : s2[3] ? {16'd0, inst[15:0]} : 32'd0;
        case (op)
            12'h800: alu = a + bb;
            12'h400: alu = a - bb;
            12'h200: alu = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            12'h100: alu = (a < bb) ? 32'd1 : 32'd0;
            12'h080: alu = a & bb;
            12'h040: alu = ~(a | bb);
            12'h020: alu = a | bb;
            12'h010: alu = a ^ bb;
            12'h008: alu = bb << a[4:0];
            12'h004: alu = bb >> a[4:0];
            12'h002: alu = $signed(bb) >>> a[4:0];
            12'h001: alu = {bb[15:0], 16'd0};
            default: alu = 32'd0;
        endcase
        res = alu;
        if (inst[31:26] == 6'd0) begin
            case (inst[5:0])
                6'h10: res = m_hi;
                6'h12: res = m_lo;
                6'h11: m_hi = r1;
                6'h13: m_lo = r1;
                6'h18: begin
                    sn = $signed(r1); sd = $signed(r2); sp = sn * sd;
                    {m_hi, m_lo} = sp;
                end
                6'h19: begin
                    un = r1; ud = r2; up = un * ud;
                    {m_hi, m_lo} = up;
                end
                6'h1A: begin
                    if (r2 == 32'd0) begin
                        m_hi = r1; m_lo = 32'hFFFF_FFFF;
                    end else begin
                        sn = $signed(r1); sd = $signed(r2);
                        m_lo = 32'(sn / sd); m_hi = 32'(sn % sd);
                    end
                end
                6'h1B: begin
                    if (r2 == 32'd0) begin
                        m_hi = r1; m_lo = 32'hFFFF_FFFF;
                    end else begin
                        m_lo = r1 / r2; m_hi = r1 % r2;
                    end
                end
                default: ;
            endcase
        end
        e.mem   = {pc, en, wen, sel, we, wa, res};
        e.rf    = {we, wa, res};
        e.en    = en;
        e.wen   = wen;
        e.addr  = alu;
        e.wdata = r2;
    endtask

    // One clock: account for what the coming edge loads into EX, then advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        loaded = 1'b0;
        if (!rst) begin
            if (stall[2] == 1'b0) begin
                model_exec(id_to_ex_bus, e);
                exp_q.push_back(e);
                loaded = 1'b1;
            end else if (stall[3] == 1'b0) begin
                exp_q.push_back(zero_e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [158:0] b);
        int n;
        id_to_ex_bus = b;
        loaded = 1'b0;
        n = 0;
        while (!loaded && n < 300) begin
            if (rand_stall) force_stall = ($urandom_range(0, 5) == 0) ? 6'b001111 : 6'b000000;
            step();
            n++;
        end
        force_stall  = '0;
        id_to_ex_bus = '0;
        chk("issue_loaded", {75'd0, loaded}, 76'd1);
    endtask

    task automatic issue_res(input string name, input logic [158:0] b, input logic [31:0] want);
        issue(b);
        chk(name, {44'd0, ex_to_rf_bus[31:0]}, {44'd0, want});
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        id_to_ex_bus = '0;
        force_stall  = '0;
        repeat (cycles) step();
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(zero_e);
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic wait_div(input string name, input int want_cycles);
        int n;
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            step();
        end
        chk(name, 76'(n), 76'(want_cycles));
    endtask

    function automatic logic [31:0] special(input logic [5:0] funct);
        return {6'd0, 20'd0, funct};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && stall[3] == 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 76'd1, 76'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ex_to_mem_bus", ex_to_mem_bus, e.mem);
                chk("ex_to_rf_bus", {38'd0, ex_to_rf_bus}, {38'd0, e.rf});
                chk("sram_en_wen", {71'd0, data_sram_en, data_sram_wen}, {71'd0, e.en, e.wen});
                chk("sram_addr", {44'd0, data_sram_addr}, {44'd0, e.addr});
                chk("sram_wdata", {44'd0, data_sram_wdata}, {44'd0, e.wdata});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [158:0] b;
        logic [31:0]  inst, r1, r2;
        logic [5:0]   funct;
        int           kind;

        vectors     = 0;
        miscompares = 0;
        zero_e      = '{mem: '0, rf: '0, en: 1'b0, wen: '0, addr: '0, wdata: '0};
        rand_stall  = 1'b0;
        do_reset(3);

        chk("reset_mem_bus", ex_to_mem_bus, 76'd0);
        chk("reset_rf_sram", {38'd0, ex_to_rf_bus}, 76'd0);
        chk("reset_stallreq", {75'd0, stallreq_for_ex}, 76'd0);
        chk("reset_sram_en", {75'd0, data_sram_en}, 76'd0);

        issue_res("ori", mk(32'h0040_0000, {6'h0D, 5'd1, 5'd2, 16'h0034}, 12'h020, 3'b001, 4'b1000,
                             1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_1200, 32'h0), 32'h0000_1234);
        chk("ori_rf_we", {75'd0, ex_to_rf_bus[37]}, 76'd1);
        issue_res("lui", mk(32'h0040_0004, {6'h0F, 5'd0, 5'd3, 16'hABCD}, 12'h001, 3'b000, 4'b1000,
                             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0), 32'hABCD_0000);
        issue_res("slt", mk(32'h0040_0008, 32'h0000_002A, 12'h200, 3'b001, 4'b0001,
                             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'h1), 32'd1);
        issue_res("sltu", mk(32'h0040_000C, 32'h0000_002B, 12'h100, 3'b001, 4'b0001,
                              1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'h1), 32'd0);
        issue_res("sra", mk(32'h0040_0010, {6'h00, 5'd0, 5'd5, 5'd6, 5'd4, 6'h03}, 12'h002, 3'b100,
                             4'b0001, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'h0, 32'h8000_0000), 32'hF800_0000);

        issue(mk(32'h100, special(6'h18), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFF_FFFF, 32'd2));
        issue_res("mult_hi", mk(32'h104, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                                1'b0, 32'h0, 32'h0), 32'hFFFF_FFFF);
        issue_res("mult_lo", mk(32'h108, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                                1'b0, 32'h0, 32'h0), 32'hFFFF_FFFE);
        issue(mk(32'h10C, special(6'h19), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFF_FFFF, 32'd2));
        issue_res("multu_hi", mk(32'h110, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                                 1'b0, 32'h0, 32'h0), 32'h0000_0001);
        issue_res("multu_lo", mk(32'h114, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                                 1'b0, 32'h0, 32'h0), 32'hFFFF_FFFE);

        issue(mk(32'h200, special(6'h1A), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFF_FFF9, 32'd2));
        wait_div("div_stall_cycles", 33);
        issue_res("div_hi", mk(32'h204, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                               1'b0, 32'h0, 32'h0), 32'hFFFF_FFFF);
        issue_res("div_lo", mk(32'h208, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                               1'b0, 32'h0, 32'h0), 32'hFFFF_FFFD);
        issue(mk(32'h20C, special(6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd100, 32'd0));
        wait_div("divu0_stall_cycles", 33);
        issue_res("divu0_hi", mk(32'h210, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                                 1'b0, 32'h0, 32'h0), 32'd100);
        issue_res("divu0_lo", mk(32'h214, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                                 1'b0, 32'h0, 32'h0), 32'hFFFF_FFFF);

        issue(mk(32'h300, special(6'h1A), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd100, 32'hFFFF_FFF9));
        wait_div("done_stall_cycles", 33);
        force_stall = 6'b001111;
        for (int i = 0; i < 5; i++) begin
            chk("done_stallreq_low", {75'd0, stallreq_for_ex}, 76'd0);
            step();
        end
        force_stall = '0;
        issue_res("done_hi", mk(32'h304, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                                1'b0, 32'h0, 32'h0), 32'd2);
        issue_res("done_lo", mk(32'h308, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                                1'b0, 32'h0, 32'h0), 32'hFFFF_FFF2);

        issue(mk(32'h400, special(6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd12345, 32'd67));
        repeat (11) step();
        chk("busy_stallreq", {75'd0, stallreq_for_ex}, 76'd1);
        do_reset(1);
        chk("abort_stallreq", {75'd0, stallreq_for_ex}, 76'd0);
        chk("abort_mem_bus", ex_to_mem_bus, 76'd0);
        issue_res("abort_hi", mk(32'h404, special(6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8,
                                 1'b0, 32'h0, 32'h0), 32'd0);
        issue_res("abort_lo", mk(32'h408, special(6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9,
                                 1'b0, 32'h0, 32'h0), 32'd0);

        issue(mk(32'h500, {6'h2B, 20'd0, 6'h04}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
                 1'b0, 32'h1000, 32'hCAFE_F00D));
        id_to_ex_bus = mk(32'h504, {6'h0D, 20'd0, 6'h01}, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0,
                          1'b1, 5'd7, 1'b0, 32'h10, 32'h0);
        force_stall = 6'b000111;
        step();
        force_stall = '0;
        chk("bubble_mem_bus", ex_to_mem_bus, 76'd0);
        chk("bubble_sram_en", {75'd0, data_sram_en}, 76'd0);
        issue(id_to_ex_bus);

        rand_stall = 1'b1;
        for (int i = 0; i < 250; i++) begin
            kind  = $urandom_range(0, 11);
            inst  = $urandom;
            r1    = $urandom;
            r2    = $urandom;
            funct = 6'h00;
            if (kind <= 5 || kind == 11) begin
                inst[31:26] = 6'($urandom_range(1, 63));
            end else begin
                case (kind)
                    6:       funct = ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h19;
                    7:       funct = ($urandom_range(0, 1) == 0) ? 6'h11 : 6'h13;
                    8, 9:    funct = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
                    default: begin
                        funct = ($urandom_range(0, 1) == 0) ? 6'h1A : 6'h1B;
                        if ($urandom_range(0, 4) == 0) r2 = 32'd0;
                        else if ($urandom_range(0, 1) == 0) r2 = 32'($urandom_range(1, 300));
                    end
                endcase
                inst[31:26] = 6'd0;
                inst[5:0]   = funct;
            end
            b = mk($urandom, inst, 12'h001 << $urandom_range(0, 12), 3'b001 << $urandom_range(0, 3),
                   4'b0001 << $urandom_range(0, 4), 1'($urandom), 4'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), r1, r2);
            issue(b);
        end
        rand_stall = 1'b0;
        repeat (40) step();
        chk("sb_drained", 76'(exp_q.size()), 76'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
